pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_if.sv | 26 ++
 rtl/pixel_writer.sv | 168 ++++++++++++++++
 tb/tb_pixel_writer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_writer_if.sv
// Pixel stream from the line drawer plus the framebuffer write port.
// No latency of its own; it only bundles the wires.
// Pixels use valid/ready; memory writes hold until mem_ready accepts them.
interface pixel_writer_if;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_color;
    logic        pix_ready;
    logic        mem_wr;
    logic [18:0] mem_addr;
    logic        mem_data;
    logic        mem_ready;

    // Environment side: offers pixels and answers memory writes
    modport master (
        output pix_valid, pix_x, pix_y, pix_color, mem_ready,
        input  pix_ready, mem_wr, mem_addr, mem_data
    );

    // Pixel writer side
    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, mem_ready,
        output pix_ready, mem_wr, mem_addr, mem_data
    );
endinterface

// File: rtl/pixel_writer.sv
// Writes line-drawer pixels into a 640x480x1 framebuffer, or clears it on request.
// Latency: pixel accepted in cycle N appears as a write in cycle N+2 (empty FIFO).
// Backpressure: pix_ready drops when address stage + 4-entry FIFO are full; writes hold until mem_ready.
// Optional PIXEL_WRITER_CLIP_EN: drop off-screen pixels and count them in dropped_count.
module pixel_writer (
    input  logic               clk,
    input  logic               reset,
    pixel_writer_if.slave      bus,
    input  logic               line_done,
    input  logic               clear_req,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        dropped_count
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_CLEAR} state_t;

    localparam logic [18:0] CLR_LAST = 19'd307199;

    state_t      state;
    logic [18:0] clr_addr;

    // One register stage holding the computed address ahead of the FIFO
    logic        stg_vld;
    logic [18:0] stg_addr;
    logic        stg_color;

    // FIFO entries are {addr, color}
    logic [19:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;

    logic        fifo_empty;
    logic        fifo_full;
    logic [2:0]  occupancy;
    logic        state_accepts;
    logic        accept;
    logic        in_bounds;
    logic        push;
    logic        pop;
    logic [18:0] x19;
    logic [18:0] y19;
    logic [18:0] pix_addr;

    assign fifo_empty = (fifo_cnt == 3'd0);
    assign fifo_full  = (fifo_cnt == 3'd4);
    // The address stage counts as a slot so an accepted pixel always has room downstream
    assign occupancy  = fifo_cnt + {2'b00, stg_vld};

    // A pixel offered together with clear_req in idle is refused: the clear wins
    assign state_accepts = (state == S_STREAM) || ((state == S_IDLE) && !clear_req);
    assign bus.pix_ready = !reset && state_accepts && (occupancy < 3'd4);
    assign accept        = bus.pix_valid && bus.pix_ready;

    // y*640 + x as shifts, truncated to 19 bits so oversized coordinates wrap
    assign x19      = {8'd0, bus.pix_x};
    assign y19      = {8'd0, bus.pix_y};
    assign pix_addr = (y19 << 9) + (y19 << 7) + x19;

`ifdef PIXEL_WRITER_CLIP_EN
    assign in_bounds = (bus.pix_x < 11'd640) && (bus.pix_y < 11'd480);
`else
    assign in_bounds = 1'b1;
`endif

    assign pop  = !fifo_empty && bus.mem_ready && (state != S_CLEAR);
    assign push = stg_vld && (!fifo_full || pop);

    // During a clear the counter owns the memory port; otherwise the FIFO head does
    assign bus.mem_wr   = (state == S_CLEAR) ? 1'b1 : !fifo_empty;
    assign bus.mem_addr = (state == S_CLEAR) ? clr_addr : fifo_mem[rd_ptr][19:1];
    assign bus.mem_data = (state == S_CLEAR) ? 1'b0 : fifo_mem[rd_ptr][0];
    assign busy         = (state != S_IDLE);

    // Address stage: capture in-bounds accepted pixels, release when pushed
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_vld   <= 1'b0;
            stg_addr  <= '0;
            stg_color <= 1'b0;
        end else if (accept && in_bounds) begin
            stg_vld   <= 1'b1;
            stg_addr  <= pix_addr;
            stg_color <= bus.pix_color;
        end else if (push) begin
            stg_vld   <= 1'b0;
        end
    end

    // 4-entry FIFO; push and pop in the same cycle leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {stg_addr, stg_color};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
        end
    end

    // Control FSM with registered frame_done pulse and clear address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            clr_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end else if (accept) begin
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (line_done) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && !stg_vld) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (bus.mem_ready) begin
                        if (clr_addr == CLR_LAST) begin
                            state      <= S_IDLE;
                            clr_addr   <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + 19'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PIXEL_WRITER_CLIP_EN
    // Saturating count of accepted pixels that fell outside the screen
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_count <= '0;
        end else if (accept && !in_bounds && (dropped_count != 16'hFFFF)) begin
            dropped_count <= dropped_count + 16'd1;
        end
    end
`else
    assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: reset, single pixel, back-pressure, simultaneous
// line_done, clipping/wrap (follows PIXEL_WRITER_CLIP_EN), full clear, reset aborts.
module tb_pixel_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        line_done;
    logic        clear_req;
    logic        busy;
    logic        frame_done;
    logic [15:0] dropped_count;
    int          total = 0;
    int          bad = 0;

    pixel_writer_if bus ();

    pixel_writer dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .line_done     (line_done),
        .clear_req     (clear_req),
        .busy          (busy),
        .frame_done    (frame_done),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic v, input int x, input int y, input logic c);
        bus.pix_valid = v;
        bus.pix_x     = 11'(x);
        bus.pix_y     = 11'(y);
        bus.pix_color = c;
    endtask

    // Raise line_done in S_STREAM and expect one frame_done pulse within a bounded time
    task automatic drain_check(input string tag);
        logic seen;
        seen = 1'b0;
        line_done = 1'b1;
        tick;
        line_done = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (frame_done) seen = 1'b1;
            else tick;
        end
        chk({tag, "_frame_done"}, 32'(seen), 1);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        tick;
        chk({tag, "_pulse_len"}, 32'(frame_done), 0);
    endtask

    initial begin
        int   writes;
        int   order_err;
        int   ready_err;
        int   data_err;
        int   fd_count;
        int   cycles;
        int   first_addr;
        int   last_addr;
        logic found;

        reset = 1'b1;
        line_done = 1'b0;
        clear_req = 1'b0;
        bus.mem_ready = 1'b1;
        set_pix(1'b0, 0, 0, 1'b0);

        // Reset values
        tick;
        tick;
        chk("rst_pix_ready", 32'(bus.pix_ready), 0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_dropped", 32'(dropped_count), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_data", 32'(bus.mem_data), 0);
        reset = 1'b0;
        #1;
        chk("idle_pix_ready", 32'(bus.pix_ready), 1);
        tick;

        // Single pixel (3,2) -> address 1283 at N+2
        set_pix(1'b1, 3, 2, 1'b1);
        #1;
        chk("sp_ready", 32'(bus.pix_ready), 1);
        tick;
        set_pix(1'b0, 0, 0, 1'b0);
        #1;
        chk("sp_wr_n1", 32'(bus.mem_wr), 0);
        chk("sp_busy", 32'(busy), 1);
        tick;
        chk("sp_wr_n2", 32'(bus.mem_wr), 1);
        chk("sp_addr", 32'(bus.mem_addr), 1283);
        chk("sp_data", 32'(bus.mem_data), 1);
        tick;
        chk("sp_wr_n3", 32'(bus.mem_wr), 0);
        drain_check("sp");

        // Back-pressure: 5 pixels (10+i,1) offered with mem_ready low
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_pix(1'b1, 10 + i, 1, i[0]);
            #1;
            chk("bp_accept_ready", 32'(bus.pix_ready), (i < 4) ? 1 : 0);
            tick;
        end
        chk("bp_hold_wr", 32'(bus.mem_wr), 1);
        chk("bp_hold_addr", 32'(bus.mem_addr), 650);
        chk("bp_full_ready", 32'(bus.pix_ready), 0);
        tick;
        chk("bp_hold_addr2", 32'(bus.mem_addr), 650);
        bus.mem_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_seq_wr", 32'(bus.mem_wr), 1);
            chk("bp_seq_addr", 32'(bus.mem_addr), 650 + k);
            chk("bp_seq_data", 32'(bus.mem_data), 32'(k[0]));
            if (k == 1) chk("bp_fifth_ready", 32'(bus.pix_ready), 1);
            tick;
            if (k == 1) bus.pix_valid = 1'b0;
        end
        chk("bp_empty_wr", 32'(bus.mem_wr), 0);
        drain_check("bp");

        // line_done together with an accepted pixel
        set_pix(1'b1, 5, 0, 1'b1);
        tick;
        set_pix(1'b1, 7, 1, 1'b1);
        line_done = 1'b1;
        #1;
        chk("sim_ready", 32'(bus.pix_ready), 1);
        tick;
        set_pix(1'b0, 0, 0, 1'b0);
        line_done = 1'b0;
        #1;
        chk("sim_wr1", 32'(bus.mem_wr), 1);
        chk("sim_addr1", 32'(bus.mem_addr), 5);
        tick;
        chk("sim_wr2", 32'(bus.mem_wr), 1);
        chk("sim_addr2", 32'(bus.mem_addr), 647);
        chk("sim_drain_ready", 32'(bus.pix_ready), 0);
        chk("sim_fd_early", 32'(frame_done), 0);
        tick;
        chk("sim_wr_done", 32'(bus.mem_wr), 0);
        chk("sim_fd_early2", 32'(frame_done), 0);
        tick;
        chk("sim_frame_done", 32'(frame_done), 1);
        chk("sim_busy", 32'(busy), 0);
        tick;

        // Clipping (when enabled) or address wrap (default)
`ifdef PIXEL_WRITER_CLIP_EN
        set_pix(1'b1, 640, 0, 1'b1);
        tick;
        set_pix(1'b1, 0, 480, 1'b1);
        tick;
        set_pix(1'b1, 639, 479, 1'b1);
        #1;
        chk("clip_wr_a", 32'(bus.mem_wr), 0);
        tick;
        bus.pix_valid = 1'b0;
        #1;
        chk("clip_wr_b", 32'(bus.mem_wr), 0);
        chk("clip_dropped", 32'(dropped_count), 2);
`else
        set_pix(1'b1, 640, 0, 1'b1);
        tick;
        set_pix(1'b1, 2047, 2047, 1'b1);
        tick;
        set_pix(1'b1, 639, 479, 1'b1);
        #1;
        chk("wrap_addr_a", 32'(bus.mem_addr), 640);
        tick;
        bus.pix_valid = 1'b0;
        #1;
        chk("wrap_addr_b", 32'(bus.mem_addr), 263551);
        chk("wrap_dropped", 32'(dropped_count), 0);
`endif
        tick;
        chk("edge_wr", 32'(bus.mem_wr), 1);
        chk("edge_addr", 32'(bus.mem_addr), 307199);
        tick;
        drain_check("clip");

        // Reset mid-stream discards queued pixels
        bus.mem_ready = 1'b0;
        set_pix(1'b1, 1, 1, 1'b1);
        tick;
        set_pix(1'b1, 2, 1, 1'b1);
        tick;
        bus.pix_valid = 1'b0;
        #1;
        chk("rs_pending_wr", 32'(bus.mem_wr), 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        tick;
        tick;
        chk("rs_wr_after", 32'(bus.mem_wr), 0);
        chk("rs_busy_after", 32'(busy), 0);

        // Full clear with mem_ready held high
        clear_req = 1'b1;
        #1;
        chk("clr_req_ready", 32'(bus.pix_ready), 0);
        tick;
        clear_req = 1'b0;
        bus.pix_valid = 1'b1;
        writes = 0; order_err = 0; ready_err = 0; data_err = 0;
        fd_count = 0; cycles = 0; first_addr = -1; last_addr = -1;
        while (!frame_done && cycles < 310000) begin
            if (bus.mem_wr && bus.mem_ready) begin
                if (writes == 0) first_addr = int'(bus.mem_addr);
                if (int'(bus.mem_addr) != writes) order_err++;
                if (bus.mem_data !== 1'b0) data_err++;
                last_addr = int'(bus.mem_addr);
                writes++;
            end
            if (bus.pix_ready !== 1'b0) ready_err++;
            clear_req = (cycles == 500);
            tick;
            cycles++;
        end
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (frame_done) fd_count++;
            tick;
        end
        chk("clr_writes", 32'(writes), 307200);
        chk("clr_cycles", 32'(cycles), 307200);
        chk("clr_first_addr", 32'(first_addr), 0);
        chk("clr_last_addr", 32'(last_addr), 307199);
        chk("clr_order_err", 32'(order_err), 0);
        chk("clr_data_err", 32'(data_err), 0);
        chk("clr_ready_err", 32'(ready_err), 0);
        chk("clr_frame_done_cnt", 32'(fd_count), 1);
        chk("clr_busy_after", 32'(busy), 0);

        // Reset during clear at address 1000
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (bus.mem_addr == 19'd1000) found = 1'b1;
            else tick;
        end
        chk("rc_reached_1000", 32'(found), 1);
        reset = 1'b1;
        tick;
        chk("rc_mem_wr", 32'(bus.mem_wr), 0);
        chk("rc_busy", 32'(busy), 0);
        chk("rc_frame_done", 32'(frame_done), 0);
        chk("rc_pix_ready", 32'(bus.pix_ready), 0);
        reset = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (frame_done) fd_count++;
        end
        chk("rc_no_frame_done", 32'(fd_count), 0);
        chk("rc_idle_wr", 32'(bus.mem_wr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
